// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU weight/data feeder.
// FSM state encoding, default geometry and the lane-slice offset helper.
package tpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadWt,
        StSettle,
        StStream,
        StDrain
    } state_e;

    localparam int unsigned DefBitWidth = 16;
    localparam int unsigned DefDepth    = 4;

    // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_line.sv
// One-lane delay line: DELAY register stages, synchronously cleared to zero.
module skew_line #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned DELAY     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic [BIT_WIDTH-1:0] data_o
);

    logic [BIT_WIDTH-1:0] stage_q [DELAY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign data_o = stage_q[DELAY-1];

endmodule

// File: rtl/tpu_feeder.sv
// Systolic-array feeder: loads a weight tile, then streams diagonally skewed data.
// Optional tile counter output enabled by defining TPU_FEEDER_TILE_CNT_EN.
module tpu_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned BIT_WIDTH    = DefBitWidth,
    parameter int unsigned DEPTH        = DefDepth,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wt_valid,
    output logic                       wt_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0] wt_col,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0] in_vec,
    output logic                       control,
    output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
    output logic                       busy,
    output logic                       tile_done,
`ifdef TPU_FEEDER_TILE_CNT_EN
    output logic [15:0]                tile_cnt,
`endif
    output logic                       err_underrun
);

    localparam int unsigned CntW = $clog2(2 * DEPTH + DRAIN_CYCLES);
    localparam logic [CntW-1:0] WtLast     = CntW'(DEPTH - 1);
    localparam logic [CntW-1:0] InLast     = CntW'(DEPTH);
    localparam logic [CntW-1:0] StreamLast = CntW'(2 * DEPTH - 2);
    localparam logic [CntW-1:0] DrainLast  = CntW'(DRAIN_CYCLES - 1);

    state_e                     state_q;
    logic [CntW-1:0]            cnt_q;
    logic                       control_q;
    logic [BIT_WIDTH*DEPTH-1:0] wt_arr_q;
    logic                       tile_done_q;
    logic                       err_underrun_q;
    logic                       wt_acc;
    logic                       feed;

    assign wt_ready = (state_q == StIdle) || (state_q == StLoadWt);
    assign in_ready = (state_q == StStream) && (cnt_q < InLast);
    assign busy     = (state_q != StIdle);
    assign wt_acc   = wt_valid && wt_ready;
    assign feed     = in_ready && in_valid;

    // One counter serves every phase; phases never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            control_q      <= 1'b0;
            wt_arr_q       <= '0;
            tile_done_q    <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            control_q   <= wt_acc;
            tile_done_q <= 1'b0;
            if (wt_acc) wt_arr_q <= wt_col;
            if (in_ready && !in_valid) err_underrun_q <= 1'b1;
            unique case (state_q)
                StIdle, StLoadWt: begin
                    if (wt_acc) begin
                        if (cnt_q == WtLast) begin
                            state_q <= StSettle;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StLoadWt;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                StSettle: begin
                    state_q <= StStream;
                    cnt_q   <= '0;
                end
                StStream: begin
                    if (cnt_q == StreamLast) begin
                        state_q     <= StDrain;
                        cnt_q       <= '0;
                        tile_done_q <= (DRAIN_CYCLES == 1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (cnt_q == DrainLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        tile_done_q <= ((cnt_q + 1'b1) == DrainLast);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign control      = control_q;
    assign wt_arr       = wt_arr_q;
    assign tile_done    = tile_done_q;
    assign err_underrun = err_underrun_q;

    // Lane k is delayed k+1 cycles; starved or idle slots carry zero.
    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
        logic [BIT_WIDTH-1:0] lane_in;
        assign lane_in = feed ? in_vec[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] : '0;
        skew_line #(
            .BIT_WIDTH(BIT_WIDTH),
            .DELAY    (k + 1)
        ) u_skew (
            .clk_i (clk),
            .rst_i (rst),
            .data_i(lane_in),
            .data_o(data_arr[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH])
        );
    end

`ifdef TPU_FEEDER_TILE_CNT_EN
    logic [15:0] tile_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) tile_cnt_q <= '0;
        else if (tile_done_q) tile_cnt_q <= tile_cnt_q + 16'd1;
    end

    assign tile_cnt = tile_cnt_q;
`endif

endmodule

// File: tb/tb_tpu_feeder.sv
// Self-checking bench for tpu_feeder: table-driven diagonal pattern plus scoreboarded
// weight/data streams, underrun, weight stall and mid-stream reset abort.
module tb_tpu_feeder;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned DC = 8;
    localparam int unsigned VW = W * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          wt_valid;
    logic          wt_ready;
    logic [VW-1:0] wt_col;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_vec;
    logic          control;
    logic [VW-1:0] wt_arr;
    logic [VW-1:0] data_arr;
    logic          busy;
    logic          tile_done;
    logic          err_underrun;
`ifdef TPU_FEEDER_TILE_CNT_EN
    logic [15:0]   tile_cnt;
`endif

    always #5 clk = ~clk;

    tpu_feeder #(
        .BIT_WIDTH   (W),
        .DEPTH       (D),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .wt_col      (wt_col),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .control     (control),
        .wt_arr      (wt_arr),
        .data_arr    (data_arr),
        .busy        (busy),
        .tile_done   (tile_done),
`ifdef TPU_FEEDER_TILE_CNT_EN
        .tile_cnt    (tile_cnt),
`endif
        .err_underrun(err_underrun)
    );

    typedef struct {
        logic [VW-1:0] dvec;
        logic          dvalid;
        logic [VW-1:0] exp_data;
    } row_t;

    row_t          tbl [2*D];
    logic [VW-1:0] cur_wt [D];
    logic [VW-1:0] sb_q [$];
    logic [VW-1:0] wt_q [$];
    int            checks = 0;
    int            failures = 0;
    int            tdone_cnt = 0;

    always @(negedge clk) if (tile_done === 1'b1) tdone_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input int gap_after, input int gap_len);
        for (int c = 0; c < D; c++) begin
            wt_valid = 1'b1;
            wt_col   = cur_wt[c];
            check("wt_ready_load", wt_ready, 1);
            wt_q.push_back(cur_wt[c]);
            tick();
            wt_valid = 1'b0;
            wt_col   = {$urandom, $urandom};
            check("control_pulse", control, 1);
            check("wt_arr_col", wt_arr, wt_q.pop_front());
            if (c == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    check("control_gap", control, 0);
                    check("wt_arr_hold", wt_arr, cur_wt[c]);
                end
            end
        end
        check("busy_settle", busy, 1);
        check("in_ready_settle", in_ready, 0);
    endtask

    task automatic run_stream(input int drop_beat, input bit use_tbl, input int abort_beat);
        logic [VW-1:0] e;
        logic [VW-1:0] v;
        logic [VW-1:0] tmp;
        logic          vld;
        tick();
        check("control_stream0", control, 0);
        sb_q.delete();
        for (int k = 0; k < D; k++) sb_q.push_back('0);
        for (int j = 0; j < 2 * D - 1; j++) begin
            check("in_ready_stream", in_ready, (j < D));
            e = sb_q.pop_front();
            sb_q.push_back('0);
            check("data_arr_sb", data_arr, e);
            if (use_tbl) check("data_arr_tbl", data_arr, tbl[j].exp_data);
            v   = use_tbl ? tbl[j].dvec : {$urandom, $urandom};
            vld = (j != drop_beat) && (use_tbl ? tbl[j].dvalid : 1'b1);
            in_vec   = v;
            in_valid = vld;
            if (j < D && vld) begin
                for (int k = 0; k < D; k++) begin
                    tmp = sb_q[k];
                    tmp[k*W +: W] = v[k*W +: W];
                    sb_q[k] = tmp;
                end
            end
            if (j == abort_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                in_valid = 1'b0;
                check("abort_data_arr", data_arr, 0);
                check("abort_control", control, 0);
                check("abort_busy", busy, 0);
                check("abort_tile_done", tile_done, 0);
                check("abort_err", err_underrun, 0);
                check("abort_in_ready", in_ready, 0);
                for (int i = 0; i < DC + 2; i++) tick();
                check("abort_idle_busy", busy, 0);
                return;
            end
            tick();
            if (j == drop_beat) check("err_underrun_set", err_underrun, 1);
        end
        in_valid = 1'b0;
        for (int d = 0; d < DC; d++) begin
            e = sb_q.pop_front();
            sb_q.push_back('0);
            check("data_arr_drain", data_arr, e);
            if (use_tbl && d == 0) check("data_arr_tbl_last", data_arr, tbl[2*D-1].exp_data);
            check("busy_drain", busy, 1);
            check("in_ready_drain", in_ready, 0);
            check("tile_done_timing", tile_done, (d == DC - 1));
            if (d == DC - 1) begin
                wt_valid = 1'b1;
                check("wt_ready_done", wt_ready, 0);
            end
            tick();
        end
        wt_valid = 1'b0;
        check("busy_after_done", busy, 0);
        check("tile_done_single", tile_done, 0);
        check("control_no_accept", control, 0);
        check("wt_ready_idle", wt_ready, 1);
    endtask

    initial begin
        tbl[0] = '{64'h000c_0008_0004_0000, 1'b1, 64'h0000_0000_0000_0000};
        tbl[1] = '{64'h000d_0009_0005_0001, 1'b1, 64'h0000_0000_0000_0000};
        tbl[2] = '{64'h000e_000a_0006_0002, 1'b1, 64'h0000_0000_0004_0001};
        tbl[3] = '{64'h000f_000b_0007_0003, 1'b1, 64'h0000_0008_0005_0002};
        tbl[4] = '{64'hdead_beef_cafe_f00d, 1'b1, 64'h000c_0009_0006_0003};
        tbl[5] = '{64'h1234_5678_9abc_def0, 1'b1, 64'h000d_000a_0007_0000};
        tbl[6] = '{64'hffff_ffff_ffff_ffff, 1'b1, 64'h000e_000b_0000_0000};
        tbl[7] = '{64'h0000_0000_0000_0000, 1'b0, 64'h000f_0000_0000_0000};

        rst = 1'b1;
        wt_valid = 1'b0;
        in_valid = 1'b0;
        wt_col = '0;
        in_vec = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_control", control, 0);
        check("rst_wt_arr", wt_arr, 0);
        check("rst_data_arr", data_arr, 0);
        check("rst_busy", busy, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_err", err_underrun, 0);
        check("rst_wt_ready", wt_ready, 1);
        check("rst_in_ready", in_ready, 0);

        // Tile A: back-to-back weights, table-checked diagonal stream.
        cur_wt[0] = 64'h0001_0000_0000_0000;
        cur_wt[1] = 64'h0000_0001_0000_0000;
        cur_wt[2] = 64'h0000_0000_0001_0000;
        cur_wt[3] = 64'h0000_0000_0000_0001;
        load_weights(-1, 0);
        run_stream(-1, 1'b1, -1);
        check("err_clean_tile", err_underrun, 0);

        // Tile B: weight stall between columns 1 and 2, data starved on beat 2.
        for (int c = 0; c < D; c++) cur_wt[c] = {$urandom, $urandom};
        load_weights(1, 3);
        run_stream(2, 1'b0, -1);
        check("err_sticky", err_underrun, 1);

        // Tile C: reset asserted during stream beat 3.
        for (int c = 0; c < D; c++) cur_wt[c] = {$urandom, $urandom};
        load_weights(-1, 0);
        run_stream(-1, 1'b0, 3);

        // Tiles D and E: fresh tiles after the abort.
        cur_wt[0] = 64'h0001_0000_0000_0000;
        cur_wt[1] = 64'h0000_0001_0000_0000;
        cur_wt[2] = 64'h0000_0000_0001_0000;
        cur_wt[3] = 64'h0000_0000_0000_0001;
        load_weights(-1, 0);
        run_stream(-1, 1'b1, -1);
        for (int c = 0; c < D; c++) cur_wt[c] = {$urandom, $urandom};
        load_weights(2, 2);
        run_stream(-1, 1'b0, -1);
        check("err_after_reset_tiles", err_underrun, 0);
`ifdef TPU_FEEDER_TILE_CNT_EN
        check("tile_cnt_two", tile_cnt, 2);
`endif
        tick();
        check("tile_done_total", tdone_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
